// File: rtl/msu_driver_pkg.sv
// Shared constants for the MSU host driver: FSM state encodings, stream word counts and word-order offsets.
// Word order on both streams is least-significant word first.
package msu_driver_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_RECV = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Outgoing job: t_start, t_final, sq_in.
  function automatic int in_count(input int axi_len, input int t_len, input int sq_in_bits);
    return (2 * t_len) / axi_len + sq_in_bits / axi_len;
  endfunction

  // Incoming result: t_current, sq_out.
  function automatic int out_count(input int axi_len, input int t_len, input int sq_out_bits);
    return t_len / axi_len + sq_out_bits / axi_len;
  endfunction

  function automatic int cnt_bits(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

  // Bit offset of sq_out inside the received result vector (it follows t_current).
  function automatic int sq_out_lsb(input int t_len);
    return t_len;
  endfunction

endpackage

// File: rtl/msu_axis_serializer.sv
// Parallel-load, right-shifting TX register: presents the low word, counts accepted words,
// and flags the first and last word of the job.
module msu_axis_serializer #(
  parameter int AXI_LEN = 32,
  parameter int WORDS   = 36,
  parameter int CNT_W   = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_load,
  input  logic [WORDS*AXI_LEN-1:0]   i_data,
  input  logic                       i_shift,
  output logic [AXI_LEN-1:0]         o_tdata,
  output logic                       o_first,
  output logic                       o_last
);

  localparam int BITS = WORDS * AXI_LEN;

  logic [BITS-1:0]  r_shift;
  logic [CNT_W-1:0] r_cnt;

  // Data path carries no reset; a fresh load always precedes use.
  always_ff @(posedge clk) begin
    if (i_load)
      r_shift <= i_data;
    else if (i_shift)
      r_shift <= {{AXI_LEN{1'b0}}, r_shift[BITS-1:AXI_LEN]};
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= '0;
    else if (i_shift)
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_tdata = r_shift[AXI_LEN-1:0];
  assign o_first = (r_cnt == '0);
  assign o_last  = (r_cnt == CNT_W'(WORDS - 1));

endmodule

// File: rtl/msu_host_driver.sv
// Host-side MSU driver: takes one parallel job, streams it out, collects the result stream.
// Define MSU_DRIVER_TIMEOUT_EN to build the RECV watchdog (res_timeout); otherwise RECV waits forever.
// Handshakes: a transfer happens on any rising edge where valid && ready; valid never waits on ready.
module msu_host_driver
  import msu_driver_pkg::*;
#(
  parameter int          AXI_LEN        = 32,
  parameter int          T_LEN          = 64,
  parameter int          SQ_IN_BITS     = 1024,
  parameter int          SQ_OUT_BITS    = 1024,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFF_FFFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [T_LEN-1:0]         job_t_start,
  input  logic [T_LEN-1:0]         job_t_final,
  input  logic [SQ_IN_BITS-1:0]    job_sq_in,
  output logic                     ap_start,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [AXI_LEN-1:0]       m_axis_tdata,
  output logic [AXI_LEN/8-1:0]     m_axis_tkeep,
  output logic                     m_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [AXI_LEN-1:0]       s_axis_tdata,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [T_LEN-1:0]         res_t_current,
  output logic [SQ_OUT_BITS-1:0]   res_sq_out,
  output logic                     res_timeout,
  output logic [1:0]               dbg_state
);

  localparam int IN_COUNT  = in_count(AXI_LEN, T_LEN, SQ_IN_BITS);
  localparam int OUT_COUNT = out_count(AXI_LEN, T_LEN, SQ_OUT_BITS);
  localparam int CNT_W     = cnt_bits(IN_COUNT, OUT_COUNT);
  localparam int RX_BITS   = T_LEN + SQ_OUT_BITS;
  localparam int SQ_LSB    = sq_out_lsb(T_LEN);

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_rx_cnt;
  logic [RX_BITS-1:0] r_rx;

  logic w_job_hs, w_tx_hs, w_rx_hs, w_res_hs;
  logic w_tx_first, w_tx_last, w_rx_last, w_wdog_expire;

  assign w_job_hs  = (r_state == ST_IDLE) && job_valid;
  assign w_tx_hs   = (r_state == ST_SEND) && m_axis_tready;
  assign w_rx_hs   = (r_state == ST_RECV) && s_axis_tvalid;
  assign w_res_hs  = (r_state == ST_DONE) && res_ready;
  assign w_rx_last = (r_rx_cnt == CNT_W'(OUT_COUNT - 1));

  msu_axis_serializer #(
    .AXI_LEN (AXI_LEN),
    .WORDS   (IN_COUNT),
    .CNT_W   (CNT_W)
  ) u_ser (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_job_hs),
    .i_data  ({job_sq_in, job_t_final, job_t_start}),
    .i_shift (w_tx_hs),
    .o_tdata (m_axis_tdata),
    .o_first (w_tx_first),
    .o_last  (w_tx_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_job_hs) r_state <= ST_SEND;
        ST_SEND: if (w_tx_hs && w_tx_last) r_state <= ST_RECV;
        ST_RECV: if ((w_rx_hs && w_rx_last) || w_wdog_expire) r_state <= ST_DONE;
        default: if (w_res_hs) r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_rx_cnt <= '0;
    else if (w_tx_hs && w_tx_last)
      r_rx_cnt <= '0;
    else if (w_rx_hs)
      r_rx_cnt <= r_rx_cnt + CNT_W'(1);
  end

  // Result words enter at the top, so the first word ends up least significant.
  always_ff @(posedge clk) begin
    if (w_rx_hs)
      r_rx <= {s_axis_tdata, r_rx[RX_BITS-1:AXI_LEN]};
  end

`ifdef MSU_DRIVER_TIMEOUT_EN
  logic [31:0] r_wdog;
  logic        r_timeout;

  assign w_wdog_expire = (r_state == ST_RECV) && !w_rx_hs && (r_wdog == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if ((r_state != ST_RECV) || w_rx_hs)
        r_wdog <= '0;
      else
        r_wdog <= r_wdog + 32'd1;
      if (w_wdog_expire)
        r_timeout <= 1'b1;
      else if (w_res_hs)
        r_timeout <= 1'b0;
    end
  end

  assign res_timeout = !reset && r_timeout;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign w_wdog_expire        = 1'b0;
  assign res_timeout          = 1'b0;
`endif

  assign job_ready     = !reset && (r_state == ST_IDLE);
  assign m_axis_tvalid = !reset && (r_state == ST_SEND);
  assign ap_start      = m_axis_tvalid && w_tx_first;
  assign m_axis_tlast  = m_axis_tvalid && w_tx_last;
  assign m_axis_tkeep  = '1;
  assign s_axis_tready = !reset && (r_state == ST_RECV);
  assign res_valid     = !reset && (r_state == ST_DONE);
  assign res_t_current = r_rx[T_LEN-1:0];
  assign res_sq_out    = r_rx[RX_BITS-1:SQ_LSB];
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_msu_host_driver.sv
// Directed bench for msu_host_driver (AXI_LEN=32, T_LEN=64, SQ=1024: 36 words out, 34 words in).
module tb_msu_host_driver;

  localparam int IN_COUNT  = 36;
  localparam int OUT_COUNT = 34;

  logic          clk = 1'b0;
  logic          reset;
  logic          job_valid;
  logic          job_ready;
  logic [63:0]   job_t_start;
  logic [63:0]   job_t_final;
  logic [1023:0] job_sq_in;
  logic          ap_start;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [31:0]   m_axis_tdata;
  logic [3:0]    m_axis_tkeep;
  logic          m_axis_tlast;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [31:0]   s_axis_tdata;
  logic          res_valid;
  logic          res_ready;
  logic [63:0]   res_t_current;
  logic [1023:0] res_sq_out;
  logic          res_timeout;
  logic [1:0]    dbg_state;

  msu_host_driver #(
    .AXI_LEN(32), .T_LEN(64), .SQ_IN_BITS(1024), .SQ_OUT_BITS(1024), .TIMEOUT_CYCLES(32'd100)
  ) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_t_start(job_t_start), .job_t_final(job_t_final), .job_sq_in(job_sq_in),
    .ap_start(ap_start),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_t_current(res_t_current), .res_sq_out(res_sq_out), .res_timeout(res_timeout),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]   exp_q[$];
  logic [31:0]   tx_words[$];
  logic          tx_last[$];
  logic          tx_ap[$];
  logic [63:0]   res_t_q[$];
  logic [1023:0] res_sq_q[$];
  int            n_job_hs = 0;
  int            job_cyc  = 0;
  int            res_cyc  = 0;
  bit            tog_mode = 1'b0;

  logic [31:0] r_a [OUT_COUNT];
  logic [31:0] r_b [OUT_COUNT];
  logic [31:0] r_z [OUT_COUNT];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // m_axis_tready pattern: constant 1, or toggling 1,0,1,0...
  always @(negedge clk) m_axis_tready = tog_mode ? ~m_axis_tready : 1'b1;

  // Monitor: sampled after the falling edge, records handshakes that complete at the next rising edge.
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      if (m_axis_tvalid && m_axis_tready) begin
        tx_words.push_back(m_axis_tdata);
        tx_last.push_back(m_axis_tlast);
        tx_ap.push_back(ap_start);
      end
      if (res_valid && res_ready) begin
        res_t_q.push_back(res_t_current);
        res_sq_q.push_back(res_sq_out);
        res_cyc = cyc;
      end
      if (job_valid && job_ready) begin
        n_job_hs++;
        job_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_exp(input int which);
    exp_q.delete();
    if (which == 0) begin
      exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd5);
      exp_q.push_back(32'd0); exp_q.push_back(32'd3);
    end else begin
      exp_q.push_back(32'd2); exp_q.push_back(32'd1); exp_q.push_back(32'hA);
      exp_q.push_back(32'd0); exp_q.push_back(32'd7); exp_q.push_back(32'hBEEF);
    end
    while (exp_q.size() < IN_COUNT) exp_q.push_back(32'd0);
  endtask

  task automatic clear_tx();
    tx_words.delete(); tx_last.delete(); tx_ap.delete();
  endtask

  task automatic set_job(input int which);
    if (which == 0) begin
      job_t_start = 64'd0; job_t_final = 64'd5; job_sq_in = 1024'd3;
    end else begin
      job_t_start = 64'h0000_0001_0000_0002; job_t_final = 64'hA; job_sq_in = 1024'hBEEF_0000_0007;
    end
  endtask

  task automatic send_job(input int which);
    int n;
    n = 0;
    @(negedge clk);
    set_job(which);
    job_valid = 1'b1;
    #1;
    while (!job_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check("job_accept_wait", 64'(n < 100), 64'd1);
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_tx(input int cnt);
    int n;
    n = 0;
    while (tx_words.size() < cnt && n < 400) begin
      @(negedge clk); #2; n++;
    end
    check("tx_word_count", 64'(tx_words.size()), 64'(cnt));
  endtask

  task automatic compare_tx(input string name);
    for (int i = 0; i < IN_COUNT; i++) begin
      check($sformatf("%s_word[%0d]", name, i), (i < tx_words.size()) ? 64'(tx_words[i]) : 'x, 64'(exp_q[i]));
      check($sformatf("%s_tlast[%0d]", name, i), (i < tx_last.size()) ? 64'(tx_last[i]) : 'x, 64'(i == IN_COUNT - 1));
      check($sformatf("%s_ap[%0d]", name, i), (i < tx_ap.size()) ? 64'(tx_ap[i]) : 'x, 64'(i == 0));
    end
  endtask

  task automatic send_result(input logic [31:0] w [OUT_COUNT]);
    int gap;
    int n;
    bit ok;
    for (int i = 0; i < OUT_COUNT; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(negedge clk); s_axis_tvalid = 1'b0;
      end
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 200) begin
        @(negedge clk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = w[i];
        #1;
        ok = s_axis_tready;
        n++;
      end
      if (!ok) begin
        check("rx_word_accept", 64'(ok), 64'd1);
        break;
      end
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_res();
    int n;
    n = 0;
    #1;
    while (!res_valid && n < 200) begin
      @(negedge clk); #1; n++;
    end
    check("res_valid_wait", 64'(res_valid), 64'd1);
  endtask

  task automatic consume_result();
    wait_res();
    @(negedge clk); res_ready = 1'b1;
    @(negedge clk); res_ready = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [63:0] exp_t, input int sq_idx, input logic [31:0] sq_val);
    logic [63:0]   t;
    logic [1023:0] s;
    check($sformatf("%s_count", name), 64'(res_t_q.size()), 64'd1);
    if (res_t_q.size() > 0) begin
      t = res_t_q.pop_front();
      s = res_sq_q.pop_front();
      check($sformatf("%s_t_current", name), t, exp_t);
      for (int j = 0; j < 32; j++)
        check($sformatf("%s_sq_word[%0d]", name, j), 64'(s[j*32 +: 32]), (j == sq_idx) ? 64'(sq_val) : 64'd0);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_job_ready"}, 64'(job_ready), 64'd0);
    check({name, "_ap_start"}, 64'(ap_start), 64'd0);
    check({name, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    check({name, "_m_tlast"}, 64'(m_axis_tlast), 64'd0);
    check({name, "_s_tready"}, 64'(s_axis_tready), 64'd0);
    check({name, "_res_valid"}, 64'(res_valid), 64'd0);
    check({name, "_res_timeout"}, 64'(res_timeout), 64'd0);
    check({name, "_tkeep"}, 64'(m_axis_tkeep), 64'hF);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0]   t0;
    logic [1023:0] s0;
    bit            stable;
    int            n;

    reset = 1'b1; job_valid = 1'b0; set_job(0);
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; res_ready = 1'b0;
    foreach (r_a[i]) begin r_a[i] = '0; r_b[i] = '0; r_z[i] = '0; end
    r_a[0] = 32'd5; r_a[2] = 32'd9;
    r_b[1] = 32'd3; r_b[33] = 32'h1234;

    repeat (2) @(negedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk); reset = 1'b0;
    #1;
    check("por_job_ready_after", 64'(job_ready), 64'd1);
    check("por_state_idle", 64'(dbg_state), 64'd0);

    // Job A with tready held high, then result A with gaps and a held result.
    clear_tx(); load_exp(0);
    send_job(0);
    wait_tx(IN_COUNT);
    @(negedge clk); #1;
    check("a_state_recv", 64'(dbg_state), 64'd2);
    check("a_s_tready", 64'(s_axis_tready), 64'd1);
    check("a_m_tvalid_off", 64'(m_axis_tvalid), 64'd0);
    check("a_no_extra_words", 64'(tx_words.size()), 64'(IN_COUNT));
    compare_tx("a");
    send_result(r_a);
    wait_res();
    t0 = res_t_current; s0 = res_sq_out; stable = 1'b1;
    repeat (10) begin
      @(negedge clk); #1;
      if (!(res_valid === 1'b1 && res_t_current === t0 && res_sq_out === s0)) stable = 1'b0;
    end
    check("a_res_hold_stable", 64'(stable), 64'd1);
    check("a_res_held_t", res_t_current, 64'd5);
    check("a_s_tready_done", 64'(s_axis_tready), 64'd0);
    @(negedge clk); res_ready = 1'b1;
    @(negedge clk); res_ready = 1'b0;
    #1 check("a_job_ready_after", 64'(job_ready), 64'd1);
    check_result("a_res", 64'd5, 0, 32'd9);

    // Same job with tready toggling.
    tog_mode = 1'b1;
    clear_tx(); load_exp(0);
    send_job(0);
    wait_tx(IN_COUNT);
    repeat (3) @(negedge clk);
    #2 check("tog_no_extra_words", 64'(tx_words.size()), 64'(IN_COUNT));
    compare_tx("tog");
    tog_mode = 1'b0;
    send_result(r_a);
    consume_result();
    check_result("tog_res", 64'd5, 0, 32'd9);

    // Reset in the middle of sending; a new job restarts from word 0.
    clear_tx();
    send_job(0);
    wait_tx(10);
    @(negedge clk); reset = 1'b1;
    #1 check_reset_outputs("mid");
    @(negedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    check("mid_job_ready_after", 64'(job_ready), 64'd1);
    check("mid_words_before_reset", 64'(tx_words.size()), 64'd10);
    clear_tx(); load_exp(1);
    send_job(1);
    wait_tx(IN_COUNT);
    compare_tx("mid_new");
    send_result(r_b);
    consume_result();
    check_result("mid_res", 64'h0000_0003_0000_0000, 31, 32'h1234);

    // No result words: watchdog (when built) or indefinite wait.
    clear_tx();
    send_job(0);
    wait_tx(IN_COUNT);
`ifdef MSU_DRIVER_TIMEOUT_EN
    n = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk); #1;
      if (res_valid) break;
      if (dbg_state == 2'd2) n++;
    end
    check("wdog_res_valid", 64'(res_valid), 64'd1);
    check("wdog_res_timeout", 64'(res_timeout), 64'd1);
    check("wdog_recv_cycles", 64'(n), 64'd100);
    @(negedge clk); res_ready = 1'b1;
    @(negedge clk); res_ready = 1'b0;
    #1;
    check("wdog_timeout_cleared", 64'(res_timeout), 64'd0);
    check("wdog_idle", 64'(job_ready), 64'd1);
    res_t_q.delete(); res_sq_q.delete();
`else
    n = 0;
    repeat (1000) begin
      @(negedge clk); #1;
      if (dbg_state == 2'd2) n++;
    end
    check("nowdog_recv_cycles", 64'(n), 64'd1000);
    check("nowdog_res_valid", 64'(res_valid), 64'd0);
    check("nowdog_res_timeout", 64'(res_timeout), 64'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #1 check("nowdog_idle", 64'(job_ready), 64'd1);
`endif

    // Back-to-back jobs with res_ready held high.
    res_ready = 1'b1;
    clear_tx(); load_exp(0);
    send_job(0);
    wait_tx(IN_COUNT);
    compare_tx("b2b_first");
    clear_tx(); load_exp(1);
    @(negedge clk);
    set_job(1);
    job_valid = 1'b1;
    n = n_job_hs;
    send_result(r_a);
    for (int k = 0; k < 50 && n_job_hs == n; k++) begin
      @(negedge clk); #2;
    end
    check("b2b_second_accepted", 64'(n_job_hs - n), 64'd1);
    @(negedge clk); job_valid = 1'b0;
    check("b2b_accept_gap", 64'(job_cyc - res_cyc), 64'd1);
    wait_tx(IN_COUNT);
    compare_tx("b2b_second");
    send_result(r_b);
    for (int k = 0; k < 50 && res_t_q.size() < 2; k++) begin
      @(negedge clk); #2;
    end
    check("b2b_result_count", 64'(res_t_q.size()), 64'd2);
    if (res_t_q.size() == 2) begin
      res_t_q.push_back(res_t_q.pop_back());
      begin
        logic [63:0]   t2;
        logic [1023:0] s2;
        t2 = res_t_q.pop_back();
        s2 = res_sq_q.pop_back();
        check_result("b2b_res1", 64'd5, 0, 32'd9);
        res_t_q.push_back(t2);
        res_sq_q.push_back(s2);
        check_result("b2b_res2", 64'h0000_0003_0000_0000, 31, 32'h1234);
      end
    end
    res_ready = 1'b0;
    @(negedge clk); #1;
    check("end_idle", 64'(dbg_state), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
